if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter CNT_W, 16, width of squash counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall  input  1  hazard-unit hold request for IF and IF/ID.
REQ-006 jump  input  1  jump decode of if_id_ins[31:26] (opcode 6'b000010), from ID-stage jump decoder.
REQ-007 br_taken  input  1  EX-stage branch resolved taken.
REQ-008 br_target  input  32  EX-stage branch target address.
REQ-009 imem_rdata  input  32  instruction word at imem_addr, combinational read.
REQ-010 imem_addr  output  32  current PC, driven to instruction memory.
REQ-011 if_id_ins  output  32  IF/ID instruction register.
REQ-012 if_id_pc4  output  32  IF/ID PC+4 register.
REQ-013 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-014 squash_cnt  output  CNT_W  count of fetched instructions squashed by jump or branch.

Function
REQ-015 pc4 SHALL be pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-016 Jump target SHALL be {if_id_pc4[31:28], if_id_ins[25:0], 2'b00}.
REQ-017 jump SHALL be effective only when if_id_valid=1 (jump_eff = jump & if_id_valid).
REQ-018 Next-state priority per cycle SHALL be: rst > br_taken > stall > jump_eff > sequential.
REQ-019 br_taken=1: pc <= br_target; IF/ID <= bubble (ins 32'h0, pc4 32'h0, valid 0); overrides stall and jump_eff.
REQ-020 stall=1 (no br_taken): pc, if_id_ins, if_id_pc4, if_id_valid SHALL hold; jump_eff ignored this cycle and acts when stall drops.
REQ-021 jump_eff=1 (no br_taken, no stall): pc <= jump target; IF/ID <= bubble (squashes the instruction fetched this cycle).
REQ-022 Sequential: pc <= pc4; if_id_ins <= imem_rdata; if_id_pc4 <= pc4; if_id_valid <= 1.
REQ-023 Jump penalty SHALL be exactly one bubble cycle; branch penalty exactly one bubble in IF/ID.
REQ-024 squash_cnt SHALL increment by 1 on each cycle where REQ-019 or REQ-021 applies, saturating at all-ones.
REQ-025 imem_addr SHALL equal pc combinationally; no other output is combinational from inputs.

Reset
REQ-026 On rst=1 at a clock edge: pc <= RESET_PC, if_id_ins <= 32'h0, if_id_pc4 <= 32'h0, if_id_valid <= 0, squash_cnt <= 0.
REQ-027 rst SHALL override stall, jump and br_taken in the same cycle, including mid-stall or mid-jump.
REQ-028 First cycle after rst deasserts SHALL fetch from RESET_PC.

Structure
REQ-029 Shared package SHALL hold NOP word 32'h0, opcode J 6'b000010, default RESET_PC, and the IF/ID register field widths.
REQ-030 IF/ID register (load/hold/bubble) SHALL be a sub-module if_id_reg; PC and next-PC mux stay in if_stage.

Verification
REQ-031 rst 2 cycles then free-run, imem returns addr-tagged words -> imem_addr 0x3000, 0x3004, 0x3008; if_id_pc4 0x3004 with valid 1 one cycle after first fetch.
REQ-032 IF/ID holds 32'h0800_0C10 (j 0x3040) with pc4 0x3008, jump=1 -> next pc 0x0000_3040, one bubble (valid 0), squash_cnt +1.
REQ-033 stall=1 for 3 cycles with jump=1 -> pc and IF/ID frozen, squash_cnt unchanged; on stall release jump to target next edge.
REQ-034 br_taken=1, br_target 0x3100 with jump=1 and stall=1 simultaneously -> pc 0x3100, bubble, squash_cnt +1 (single increment).
REQ-035 jump=1 with if_id_valid=0 -> ignored, pc advances by 4, no squash.
REQ-036 rst asserted mid-stall with squash_cnt=5 -> pc 0x3000, valid 0, squash_cnt 0; saturation check: force CNT_W=2, four squashes -> squash_cnt stays 3.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants, IF/ID field widths and control encoding for the fetch stage.
package if_stage_pkg;

  localparam int INS_W = 32;
  localparam int PC_W  = 32;

  localparam logic [INS_W-1:0] NOP_WORD     = '0;
  localparam logic [5:0]       OP_J         = 6'b000010;
  localparam logic [PC_W-1:0]  DEF_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IFID_LOAD,
    IFID_HOLD,
    IFID_BUBBLE
  } ifid_ctrl_e;

  // J-type target: upper nibble of the delay-slot-free pc4, word index from the instruction.
  function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0] pc4,
                                                   input logic [25:0]     idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  ifid_ctrl_e       ctrl,
  input  logic [INS_W-1:0] ins_in,
  input  logic [PC_W-1:0]  pc4_in,
  output logic [INS_W-1:0] ins,
  output logic [PC_W-1:0]  pc4,
  output logic             valid
);

  logic [INS_W-1:0] ins_d,   ins_q;
  logic [PC_W-1:0]  pc4_d,   pc4_q;
  logic             valid_d, valid_q;

  always_comb begin
    ins_d   = ins_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (ctrl)
      IFID_LOAD: begin
        ins_d   = ins_in;
        pc4_d   = pc4_in;
        valid_d = 1'b1;
      end
      IFID_BUBBLE: begin
        ins_d   = NOP_WORD;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_q   <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ins_q   <= ins_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign ins   = ins_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and squash counting.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic [INS_W-1:0] imem_rdata,
  output logic [PC_W-1:0]  imem_addr,
  output logic [INS_W-1:0] if_id_ins,
  output logic [PC_W-1:0]  if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] squash_cnt
);

  logic [PC_W-1:0]  pc_d, pc_q;
  logic [CNT_W-1:0] squash_cnt_d, squash_cnt_q;
  logic [PC_W-1:0]  pc4;
  logic             jump_eff;
  logic             squash;
  ifid_ctrl_e       ifid_ctrl;

  assign pc4      = pc_q + 32'd4;
  assign jump_eff = jump & if_id_valid;

  // A jump seen during a stall is not lost: IF/ID holds, so it re-presents when stall drops.
  always_comb begin
    pc_d      = pc4;
    ifid_ctrl = IFID_LOAD;
    squash    = 1'b0;
    if (br_taken) begin
      pc_d      = br_target;
      ifid_ctrl = IFID_BUBBLE;
      squash    = 1'b1;
    end else if (stall) begin
      pc_d      = pc_q;
      ifid_ctrl = IFID_HOLD;
    end else if (jump_eff) begin
      pc_d      = jump_target(if_id_pc4, if_id_ins[25:0]);
      ifid_ctrl = IFID_BUBBLE;
      squash    = 1'b1;
    end
  end

  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (squash && (squash_cnt_q != {CNT_W{1'b1}}))
      squash_cnt_d = squash_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      squash_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .ctrl   (ifid_ctrl),
    .ins_in (imem_rdata),
    .pc4_in (pc4),
    .ins    (if_id_ins),
    .pc4    (if_id_pc4),
    .valid  (if_id_valid)
  );

  assign imem_addr  = pc_q;
  assign squash_cnt = squash_cnt_q;

endmodule
